// File: rtl/conv_acc_top.sv
// Multi-channel 3x3 valid-convolution engine: fetches weights and the IFM with read strobes,
// accumulates per-channel window sums in a psum buffer and streams the OFM in raster order.
//   state    | meaning
//   IDLE     | waiting for start_conv
//   LOAD_WGT | one weight word per channel for the current kernel
//   LOAD_IFM | full IFM stream, channel-major, windows computed on the fly
//   GAP      | one idle cycle, advance kernel counter
//   FIN      | done pulse
module conv_acc_top #(
    parameter int DATA_WIDTH       = 16,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int IFM_DATA_WIDTH   = 8,
    parameter int IFM_WIDTH        = 64,
    parameter int IFM_HEIGHT       = 64,
    parameter int KERNEL_SIZE      = 3,
    parameter int NUM_CHANNEL      = 3,
    parameter int KERNEL_NUM       = 8,
    parameter int FIFO_SIZE        = 62,
    parameter int INDEX_WIDTH      = 10,
    parameter int FIFO_SIZE_PSUM   = 62*62*3,
    parameter int INDEX_WIDTH_PSUM = 16
) (
    input  logic                                               clk1,
    input  logic                                               rst_n,
    input  logic                                               start_conv,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]    wgt,
    input  logic [IFM_DATA_WIDTH-1:0]                          ifm,
    output logic                                               wgt_read,
    output logic                                               ifm_read,
    output logic [DATA_WIDTH-1:0]                              ofm_data,
    output logic                                               ofm_valid,
    output logic                                               busy,
    output logic                                               done
);
    localparam int K      = KERNEL_SIZE;
    localparam int WB_W   = WEIGHT_WIDTH*K*K;
    localparam int COL_W  = $clog2(IFM_WIDTH);
    localparam int CH_W   = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam int KN_W   = $clog2(KERNEL_NUM+1);
    localparam int PS_AW  = (INDEX_WIDTH_PSUM < $clog2(FIFO_SIZE_PSUM)) ? INDEX_WIDTH_PSUM
                                                                       : $clog2(FIFO_SIZE_PSUM);
    localparam int PROD_W = IFM_DATA_WIDTH + WEIGHT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WGT,
        S_LOAD_IFM,
        S_GAP,
        S_FIN
    } state_t;

    state_t r_state, w_next;

    logic [CH_W-1:0]           r_wcnt;
    logic [CH_W-1:0]           r_ch;
    logic [KN_W-1:0]           r_kcnt;
    logic [INDEX_WIDTH-1:0]    r_row;
    logic [INDEX_WIDTH-1:0]    r_col;
    logic [WB_W-1:0]           r_wbank [NUM_CHANNEL];
    logic [IFM_DATA_WIDTH-1:0] r_lb    [K-1][IFM_WIDTH];
    logic [IFM_DATA_WIDTH-1:0] r_win   [K][K-1];
    logic [DATA_WIDTH-1:0]     r_psum  [FIFO_SIZE_PSUM];
    logic [DATA_WIDTH-1:0]     r_ofm_data;
    logic                      r_ofm_valid;

    logic [IFM_DATA_WIDTH-1:0] w_col_vec  [K];
    logic [IFM_DATA_WIDTH-1:0] w_win_full [K][K];
    logic [WB_W-1:0]           w_wsel;
    logic [DATA_WIDTH-1:0]     w_sum;
    logic [DATA_WIDTH-1:0]     w_acc;
    logic [PS_AW-1:0]          w_paddr;
    logic w_wgt_last, w_col_last, w_row_last, w_ch_last, w_pix_last;
    logic w_ifm_fire, w_win_fire;

    assign w_wgt_last = (r_wcnt == CH_W'(NUM_CHANNEL-1));
    assign w_col_last = (r_col == INDEX_WIDTH'(IFM_WIDTH-1));
    assign w_row_last = (r_row == INDEX_WIDTH'(IFM_HEIGHT-1));
    assign w_ch_last  = (r_ch == CH_W'(NUM_CHANNEL-1));
    assign w_pix_last = w_col_last && w_row_last && w_ch_last;
    assign w_ifm_fire = (r_state == S_LOAD_IFM);
    // Only windows fully inside the current plane fire, so stale line-buffer data is never used.
    assign w_win_fire = w_ifm_fire && (r_row >= INDEX_WIDTH'(K-1)) && (r_col >= INDEX_WIDTH'(K-1));

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        if (gi < K-1) begin : g_lb
            assign w_col_vec[gi] = r_lb[gi][r_col[COL_W-1:0]];
        end else begin : g_in
            assign w_col_vec[gi] = ifm;
        end
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            if (gj < K-1) begin : g_old
                assign w_win_full[gi][gj] = r_win[gi][gj];
            end else begin : g_new
                assign w_win_full[gi][gj] = w_col_vec[gi];
            end
        end
    end

    assign w_wsel = r_wbank[r_ch];

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_sum = w_sum + DATA_WIDTH'(PROD_W'(w_win_full[i][j]) *
                        PROD_W'(w_wsel[(K*K-1-(i*K+j))*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            end
        end
    end

    assign w_paddr = PS_AW'((32'(r_row) - 32'(K-1)) * 32'(FIFO_SIZE) + (32'(r_col) - 32'(K-1)));
    assign w_acc   = (r_ch == '0) ? w_sum : r_psum[w_paddr] + w_sum;

    always_ff @(posedge clk1) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start_conv) w_next = S_LOAD_WGT;
            S_LOAD_WGT: if (w_wgt_last) w_next = S_LOAD_IFM;
            S_LOAD_IFM: if (w_pix_last) w_next = S_GAP;
            S_GAP:      w_next = (r_kcnt == KN_W'(KERNEL_NUM-1)) ? S_FIN : S_LOAD_WGT;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst_n) begin
            r_wcnt      <= '0;
            r_ch        <= '0;
            r_kcnt      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_ofm_data  <= '0;
            r_ofm_valid <= 1'b0;
            for (int c = 0; c < NUM_CHANNEL; c++) r_wbank[c] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K-1; j++) r_win[i][j] <= '0;
        end else begin
            r_ofm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_conv) begin
                        r_kcnt <= '0;
                        r_wcnt <= '0;
                        r_ch   <= '0;
                        r_row  <= '0;
                        r_col  <= '0;
                    end
                end
                S_LOAD_WGT: begin
                    r_wbank[r_wcnt] <= wgt;
                    r_wcnt          <= w_wgt_last ? '0 : r_wcnt + 1'b1;
                end
                S_LOAD_IFM: begin
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K-2; j++) r_win[i][j] <= r_win[i][j+1];
                        r_win[i][K-2] <= w_col_vec[i];
                    end
                    if (w_col_last) begin
                        r_col <= '0;
                        if (w_row_last) begin
                            r_row <= '0;
                            r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (w_win_fire && w_ch_last) begin
                        r_ofm_valid <= 1'b1;
                        r_ofm_data  <= w_acc;
                    end
                end
                S_GAP:   r_kcnt <= r_kcnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; every read location is written earlier in the same plane/kernel.
    always_ff @(posedge clk1) begin
        if (w_ifm_fire) begin
            for (int i = 0; i < K-1; i++) r_lb[i][r_col[COL_W-1:0]] <= w_col_vec[i+1];
        end
        if (w_win_fire) r_psum[w_paddr] <= w_acc;
    end

    assign wgt_read  = (r_state == S_LOAD_WGT);
    assign ifm_read  = (r_state == S_LOAD_IFM);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign ofm_data  = r_ofm_data;
    assign ofm_valid = r_ofm_valid;
endmodule

// File: tb/tb_conv_acc_top.sv
// Bench for conv_acc_top on a reduced 8x8x3 IFM with 3 kernels; a plain-arithmetic
// convolution model fills an expected queue that is checked against every ofm_valid beat.
module tb_conv_acc_top;
    localparam int H = 8, W = 8, NC = 3, KN = 3, K = 3;
    localparam int FS = W - K + 1;
    localparam int PIX = H * W;
    localparam int PLANE = NC * PIX;
    localparam int BUDGET = KN * (PLANE + NC + 1) + 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_conv = 1'b0;
    logic [71:0] wgt = '0;
    logic [7:0]  ifm = '0;
    logic        wgt_read, ifm_read, ofm_valid, busy, done;
    logic [15:0] ofm_data;

    always #5 clk = ~clk;

    conv_acc_top #(
        .DATA_WIDTH(16), .WEIGHT_WIDTH(8), .IFM_DATA_WIDTH(8),
        .IFM_WIDTH(W), .IFM_HEIGHT(H), .KERNEL_SIZE(K), .NUM_CHANNEL(NC),
        .KERNEL_NUM(KN), .FIFO_SIZE(FS), .INDEX_WIDTH(10),
        .FIFO_SIZE_PSUM(FS*FS*NC), .INDEX_WIDTH_PSUM(16)
    ) dut (
        .clk1(clk), .rst_n(rst_n), .start_conv(start_conv), .wgt(wgt), .ifm(ifm),
        .wgt_read(wgt_read), .ifm_read(ifm_read), .ofm_data(ofm_data),
        .ofm_valid(ofm_valid), .busy(busy), .done(done)
    );

    logic [7:0]  img [PLANE];
    logic [71:0] wk  [KN][NC];
    logic [15:0] exp_q [$];

    int checks = 0, failures = 0;
    int icnt = 0, wcnt = 0, dcnt = 0, ocnt = 0, bad = 0;
    int ibase = 0, wbase = 0;
    bit chk_en = 1'b0;

    int  wl = 0, il = 0, lowl = 0;
    bit  pw = 1'b0, pi = 1'b0, hadf = 1'b0;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
        end
    endtask

    // Memory model plus strobe-shape monitor.
    always @(negedge clk) begin
        if (wgt_read) begin
            wgt = wk[((wcnt - wbase) / NC) % KN][(wcnt - wbase) % NC];
            wcnt++;
        end
        if (ifm_read) begin
            ifm = img[(icnt - ibase) % PLANE];
            icnt++;
        end
        if (done) dcnt++;
        if (wgt_read) wl++;
        else begin
            if (pw && wl != NC) bad++;
            wl = 0;
        end
        if (ifm_read) begin
            if (!pi && hadf && lowl != NC + 1) bad++;
            il++;
        end else begin
            if (pi) begin
                if (il != PLANE) bad++;
                hadf = 1'b1;
                il = 0;
                lowl = 0;
            end
            lowl++;
        end
        if (!busy) hadf = 1'b0;
        pw = wgt_read;
        pi = ifm_read;
    end

    always @(negedge clk) begin
        if (ofm_valid) begin
            if (!chk_en) chk("unexpected_ofm_valid", ofm_valid, 0);
            else if (exp_q.size() == 0) chk("extra_ofm_beat", ofm_valid, 0);
            else begin
                chk($sformatf("ofm_data[%0d]", ocnt), ofm_data, exp_q.pop_front());
                ocnt++;
            end
        end
    end

    function automatic logic [7:0] wbyte(input logic [71:0] w, input int i, input int j);
        return w[(8 - (i * 3 + j)) * 8 +: 8];
    endfunction

    task automatic build_exp();
        int unsigned acc;
        exp_q.delete();
        for (int k = 0; k < KN; k++)
            for (int r = 0; r < FS; r++)
                for (int c = 0; c < FS; c++) begin
                    acc = 0;
                    for (int ch = 0; ch < NC; ch++)
                        for (int i = 0; i < K; i++)
                            for (int j = 0; j < K; j++)
                                acc += img[ch * PIX + (r + i) * W + (c + j)] * wbyte(wk[k][ch], i, j);
                    exp_q.push_back(acc[15:0]);
                end
    endtask

    task automatic fill(input int t);
        logic [71:0] w;
        for (int p = 0; p < PLANE; p++) begin
            case (t)
                3:       img[p] = 8'hff;
                4:       img[p] = 8'(p % W);
                6:       img[p] = 8'(((p / PIX) * 37 + ((p % PIX) / W) * 11 + (p % W) * 5 + 1) & 255);
                default: img[p] = 8'h01;
            endcase
        end
        for (int k = 0; k < KN; k++)
            for (int ch = 0; ch < NC; ch++) begin
                case (t)
                    1:       w = {9{8'h01}};
                    2:       w = 72'h010203010203010203;
                    3:       w = {9{8'hff}};
                    4:       w = (ch == 0) ? {8'h01, 64'h0} : 72'h0;
                    5:       w = {9{8'(k + 1)}};
                    default: begin
                        for (int p = 0; p < 9; p++) w[(8 - p) * 8 +: 8] = 8'((k * 29 + ch * 13 + p * 7 + 3) & 255);
                    end
                endcase
                wk[k][ch] = w;
            end
        build_exp();
    endtask

    task automatic do_run(input string nm, input bit restart);
        int b_w, b_i, b_d, b_o, b_b, n;
        b_w = wcnt; b_i = icnt; b_d = dcnt; b_o = ocnt; b_b = bad;
        ibase = icnt; wbase = wcnt;
        chk_en = 1'b1;
        @(negedge clk) start_conv = 1'b1;
        @(negedge clk) start_conv = 1'b0;
        if (restart) begin
            repeat (300) @(negedge clk);
            start_conv = 1'b1;
            @(negedge clk) start_conv = 1'b0;
        end
        n = 0;
        while (dcnt == b_d && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, (dcnt != b_d) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        chk({nm, "_done_pulses"}, dcnt - b_d, 1);
        chk({nm, "_ofm_beats"}, ocnt - b_o, KN * FS * FS);
        chk({nm, "_expected_left"}, exp_q.size(), 0);
        chk({nm, "_wgt_reads"}, wcnt - b_w, KN * NC);
        chk({nm, "_ifm_reads"}, icnt - b_i, KN * PLANE);
        chk({nm, "_strobe_shape_errors"}, bad - b_b, 0);
        chk({nm, "_busy_after"}, busy, 0);
        chk_en = 1'b0;
        if (n >= BUDGET) begin
            rst_n = 1'b1;
            @(negedge clk) rst_n = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic abort_test();
        int b_d, n;
        fill(6);
        b_d = dcnt;
        ibase = icnt; wbase = wcnt;
        chk_en = 1'b0;
        @(negedge clk) start_conv = 1'b1;
        @(negedge clk) start_conv = 1'b0;
        n = 0;
        while (icnt - ibase < 50 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_ifm", (icnt - ibase >= 50) ? 1 : 0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ifm_read", ifm_read, 0);
        chk("abort_wgt_read", wgt_read, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ofm_valid", ofm_valid, 0);
        chk("abort_ofm_data", ofm_data, 0);
        rst_n = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", dcnt - b_d, 0);
        chk("abort_idle", busy, 0);
        fill(6);
        do_run("restart", 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wgt_read", wgt_read, 0);
        chk("rst_ifm_read", ifm_read, 0);
        chk("rst_ofm_valid", ofm_valid, 0);
        chk("rst_ofm_data", ofm_data, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        fill(1);
        chk("model_ones_first", exp_q[0], 27);
        chk("model_ones_last", exp_q[exp_q.size() - 1], 27);
        do_run("ones", 1'b0);

        fill(2);
        chk("model_rowweights", exp_q[0], 54);
        do_run("rowweights", 1'b0);

        fill(3);
        chk("model_wrap", exp_q[0], 51739);
        do_run("wrap", 1'b0);

        fill(4);
        chk("model_ramp_c0", exp_q[0], 0);
        chk("model_ramp_c3", exp_q[3], 3);
        chk("model_ramp_end", exp_q[FS * FS - 1], FS - 1);
        do_run("ramp", 1'b0);

        fill(5);
        chk("model_kern0", exp_q[0], 27);
        chk("model_kern1", exp_q[FS * FS], 54);
        chk("model_kern2", exp_q[2 * FS * FS], 81);
        do_run("per_kernel", 1'b0);

        fill(6);
        do_run("mixed", 1'b0);

        abort_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
